// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sharing one external combinational ALU
module alu_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned OP_W       = 4,
    parameter int unsigned FIXED_PRIO = 0,
    parameter logic [OP_W-1:0] IDLE_OP = '0
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_op1,
    input  logic [DATA_W-1:0] req0_op2,
    input  logic [OP_W-1:0]   req0_operation,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,
    output logic              rsp0_overflow,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_op1,
    input  logic [DATA_W-1:0] req1_op2,
    input  logic [OP_W-1:0]   req1_operation,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,
    output logic              rsp1_overflow,

    output logic [DATA_W-1:0] alu_operand1,
    output logic [DATA_W-1:0] alu_operand2,
    output logic [OP_W-1:0]   alu_operation,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_is_zero,
    input  logic              alu_overflow,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   id_reg;
    logic   grant0;
    logic   grant1;
    logic   rsp_done;

    // Requester 0 wins a tie under fixed priority, or when requester 1 was served last.
    assign grant0 = req0_valid & (~req1_valid | (FIXED_PRIO != 0) | last_grant);
    assign grant1 = req1_valid & ~grant0;

    assign req0_ready = reset & (state == IDLE) & grant0;
    assign req1_ready = reset & (state == IDLE) & grant1;

    assign rsp_done = id_reg ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            id_reg        <= 1'b0;
            alu_operand1  <= '0;
            alu_operand2  <= '0;
            alu_operation <= IDLE_OP;
            rsp0_valid    <= 1'b0;
            rsp0_result   <= '0;
            rsp0_zero     <= 1'b0;
            rsp0_overflow <= 1'b0;
            rsp1_valid    <= 1'b0;
            rsp1_result   <= '0;
            rsp1_zero     <= 1'b0;
            rsp1_overflow <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        id_reg        <= req1_ready;
                        alu_operand1  <= req1_ready ? req1_op1 : req0_op1;
                        alu_operand2  <= req1_ready ? req1_op2 : req0_op2;
                        alu_operation <= req1_ready ? req1_operation : req0_operation;
                        busy          <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (id_reg) begin
                        rsp1_valid    <= 1'b1;
                        rsp1_result   <= alu_result;
                        rsp1_zero     <= alu_is_zero;
                        rsp1_overflow <= alu_overflow;
                    end else begin
                        rsp0_valid    <= 1'b1;
                        rsp0_result   <= alu_result;
                        rsp0_zero     <= alu_is_zero;
                        rsp0_overflow <= alu_overflow;
                    end
                    last_grant    <= id_reg;
                    alu_operation <= IDLE_OP;
                    state         <= RESP;
                end
                RESP: begin
                    if (rsp_done) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd6;

    logic        clk;
    logic        reset;
    int          total;
    int          bad;

    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero, rsp0_overflow;
    logic [31:0] req0_op1, req0_op2, rsp0_result;
    logic [3:0]  req0_operation;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero, rsp1_overflow;
    logic [31:0] req1_op1, req1_op2, rsp1_result;
    logic [3:0]  req1_operation;
    logic [31:0] alu_operand1, alu_operand2, alu_result;
    logic [3:0]  alu_operation;
    logic        alu_is_zero, alu_overflow, busy;

    logic        f_req0_valid, f_req0_ready, f_rsp0_valid, f_rsp0_zero, f_rsp0_overflow;
    logic [31:0] f_rsp0_result;
    logic        f_req1_valid, f_req1_ready, f_rsp1_valid, f_rsp1_zero, f_rsp1_overflow;
    logic [31:0] f_rsp1_result;
    logic [31:0] f_alu_operand1, f_alu_operand2, f_alu_result;
    logic [3:0]  f_alu_operation;
    logic        f_alu_is_zero, f_alu_overflow, f_busy;

    function automatic logic [33:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        v;
        case (op)
            OP_ADD: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            OP_SUB: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            default: begin r = a & b; v = 1'b0; end
        endcase
        return {v, (r == 32'd0), r};
    endfunction

    assign {alu_overflow, alu_is_zero, alu_result} = alu_f(alu_operation, alu_operand1, alu_operand2);
    assign {f_alu_overflow, f_alu_is_zero, f_alu_result} = alu_f(f_alu_operation, f_alu_operand1, f_alu_operand2);

    alu_arbiter #(.DATA_W(32), .OP_W(4), .FIXED_PRIO(0), .IDLE_OP(4'b0000)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req0_operation(req0_operation), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero), .rsp0_overflow(rsp0_overflow),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1), .req1_op2(req1_op2),
        .req1_operation(req1_operation), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_overflow(rsp1_overflow),
        .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .alu_operation(alu_operation),
        .alu_result(alu_result), .alu_is_zero(alu_is_zero), .alu_overflow(alu_overflow),
        .busy(busy)
    );

    alu_arbiter #(.DATA_W(32), .OP_W(4), .FIXED_PRIO(1), .IDLE_OP(4'b0000)) dut_fp (
        .clk(clk), .reset(reset),
        .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_op1(32'd2), .req0_op2(32'd2),
        .req0_operation(OP_ADD), .rsp0_valid(f_rsp0_valid), .rsp0_ready(1'b1),
        .rsp0_result(f_rsp0_result), .rsp0_zero(f_rsp0_zero), .rsp0_overflow(f_rsp0_overflow),
        .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_op1(32'd2), .req1_op2(32'd2),
        .req1_operation(OP_ADD), .rsp1_valid(f_rsp1_valid), .rsp1_ready(1'b1),
        .rsp1_result(f_rsp1_result), .rsp1_zero(f_rsp1_zero), .rsp1_overflow(f_rsp1_overflow),
        .alu_operand1(f_alu_operand1), .alu_operand2(f_alu_operand2), .alu_operation(f_alu_operation),
        .alu_result(f_alu_result), .alu_is_zero(f_alu_is_zero), .alu_overflow(f_alu_overflow),
        .busy(f_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset;
        reset = 1'b0;
        req0_valid = 0; req0_op1 = 0; req0_op2 = 0; req0_operation = 0; rsp0_ready = 0;
        req1_valid = 0; req1_op1 = 0; req1_op2 = 0; req1_operation = 0; rsp1_ready = 0;
        f_req0_valid = 0; f_req1_valid = 0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=00", {rsp0_valid, rsp1_valid}); end
        total++; if (rsp0_result !== 32'd0 || rsp1_result !== 32'd0) begin bad++; $display("FAIL reset_result got=%0h/%0h exp=0/0", rsp0_result, rsp1_result); end
        total++; if (alu_operation !== 4'd0 || alu_operand1 !== 32'd0 || alu_operand2 !== 32'd0) begin bad++; $display("FAIL reset_alu got=%0h %0h %0h exp=0 0 0", alu_operation, alu_operand1, alu_operand2); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_req0_add;
        req0_valid = 1; req0_op1 = 32'd5; req0_op2 = 32'd3; req0_operation = OP_ADD; rsp0_ready = 1;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL add_ready got=%b exp=10", {req0_ready, req1_ready}); end
        @(negedge clk);
        req0_valid = 0;
        #1;
        total++; if (req0_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL add_issue_state got=ready%0b busy%0b exp=ready0 busy1", req0_ready, busy); end
        total++; if (alu_operation !== OP_ADD || alu_operand1 !== 32'd5 || alu_operand2 !== 32'd3) begin bad++; $display("FAIL add_alu_drive got=%0h %0h %0h exp=2 5 3", alu_operation, alu_operand1, alu_operand2); end
        total++; if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL add_early_rsp got=%0b exp=0", rsp0_valid); end
        @(negedge clk);
        #1;
        total++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin bad++; $display("FAIL add_rsp_valid got=%b exp=10", {rsp0_valid, rsp1_valid}); end
        total++; if ({rsp0_overflow, rsp0_zero, rsp0_result} !== {2'b00, 32'd8}) begin bad++; $display("FAIL add_result got=%0h z%0b v%0b exp=8 z0 v0", rsp0_result, rsp0_zero, rsp0_overflow); end
        total++; if (alu_operation !== 4'd0) begin bad++; $display("FAIL add_idle_op got=%0h exp=0", alu_operation); end
        @(negedge clk);
        #1;
        total++; if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL add_done got=valid%0b busy%0b exp=valid0 busy0", rsp0_valid, busy); end
    endtask

    task automatic test_req1_overflow;
        req1_valid = 1; req1_op1 = 32'h7FFF_FFFF; req1_op2 = 32'h1; req1_operation = OP_ADD; rsp1_ready = 1;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL ovf_ready got=%b exp=01", {req0_ready, req1_ready}); end
        @(negedge clk);
        req1_valid = 0;
        @(negedge clk);
        #1;
        total++; if ({rsp0_valid, rsp1_valid} !== 2'b01) begin bad++; $display("FAIL ovf_rsp_valid got=%b exp=01", {rsp0_valid, rsp1_valid}); end
        total++; if (rsp1_result !== 32'h8000_0000 || rsp1_overflow !== 1'b1 || rsp1_zero !== 1'b0) begin bad++; $display("FAIL ovf_result got=%0h v%0b z%0b exp=80000000 v1 z0", rsp1_result, rsp1_overflow, rsp1_zero); end
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        int g[$];
        req0_valid = 1; req0_op1 = 32'd5; req0_op2 = 32'd5; req0_operation = OP_SUB; rsp0_ready = 1;
        req1_valid = 1; req1_op1 = 32'd5; req1_op2 = 32'd5; req1_operation = OP_SUB; rsp1_ready = 1;
        for (int i = 0; i < 12; i++) begin
            #1;
            total++; if (req0_ready && req1_ready) begin bad++; $display("FAIL rr_exclusive got=11 exp=not11 cycle=%0d", i); end
            if (req0_ready) g.push_back(0);
            else if (req1_ready) g.push_back(1);
            if (rsp0_valid || rsp1_valid) begin
                total++;
                if ((rsp0_valid ? {rsp0_zero, rsp0_result} : {rsp1_zero, rsp1_result}) !== {1'b1, 32'd0}) begin
                    bad++; $display("FAIL rr_result got=%0h/%0h exp=0 zero=1 cycle=%0d", rsp0_result, rsp1_result, i);
                end
            end
            @(negedge clk);
        end
        req0_valid = 0; req1_valid = 0;
        total++; if (g.size() != 4) begin bad++; $display("FAIL rr_grant_count got=%0d exp=4", g.size()); end
        for (int k = 0; k < g.size() && k < 4; k++) begin
            total++; if (g[k] != (k % 2)) begin bad++; $display("FAIL rr_grant_order got=%0d exp=%0d idx=%0d", g[k], k % 2, k); end
        end
    endtask

    task automatic test_fixed_prio;
        int n0;
        int n1;
        n0 = 0; n1 = 0;
        f_req0_valid = 1; f_req1_valid = 1;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (f_req0_ready) n0++;
            if (f_req1_ready) n1++;
            if (f_rsp0_valid) begin
                total++; if (f_rsp0_result !== 32'd4) begin bad++; $display("FAIL fp_result got=%0h exp=4", f_rsp0_result); end
            end
            @(negedge clk);
        end
        f_req0_valid = 0; f_req1_valid = 0;
        total++; if (n1 != 0) begin bad++; $display("FAIL fp_req1_ready got=%0d exp=0", n1); end
        total++; if (n0 != 10) begin bad++; $display("FAIL fp_req0_grants got=%0d exp=10", n0); end
    endtask

    task automatic test_backpressure;
        req0_valid = 1; req0_op1 = 32'd1; req0_op2 = 32'd2; req0_operation = OP_ADD; rsp0_ready = 0;
        req1_valid = 1; req1_op1 = 32'd4; req1_op2 = 32'd4; req1_operation = OP_ADD; rsp1_ready = 1;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL bp_grant got=%b exp=10", {req0_ready, req1_ready}); end
        @(negedge clk);
        req0_valid = 0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd3 || req1_ready !== 1'b0 || busy !== 1'b1 || rsp1_valid !== 1'b0) begin
                bad++; $display("FAIL bp_hold got=v%0b r%0h rdy1%0b busy%0b exp=v1 r3 rdy1 0 busy1 cycle=%0d", rsp0_valid, rsp0_result, req1_ready, busy, i);
            end
            @(negedge clk);
        end
        rsp0_ready = 1;
        #1;
        total++; if (rsp0_valid !== 1'b1) begin bad++; $display("FAIL bp_release_valid got=%0b exp=1", rsp0_valid); end
        @(negedge clk);
        rsp0_ready = 0;
        #1;
        total++; if (rsp0_valid !== 1'b0 || busy !== 1'b0 || req1_ready !== 1'b1) begin bad++; $display("FAIL bp_after got=v%0b busy%0b rdy1%0b exp=v0 busy0 rdy1 1", rsp0_valid, busy, req1_ready); end
        @(negedge clk);
        req1_valid = 0;
        @(negedge clk);
        #1;
        total++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'd8) begin bad++; $display("FAIL bp_req1_rsp got=v%0b r%0h exp=v1 r8", rsp1_valid, rsp1_result); end
        @(negedge clk);
    endtask

    task automatic test_reset_in_issue;
        req0_valid = 1; req0_op1 = 32'd9; req0_op2 = 32'd9; req0_operation = OP_ADD; rsp0_ready = 1;
        repeat (3) @(negedge clk);
        req0_valid = 0;
        @(negedge clk);
        req0_valid = 1; req0_op1 = 32'd7; req0_op2 = 32'd1;
        @(negedge clk);
        req0_valid = 0;
        #1;
        total++; if (busy !== 1'b1 || alu_operation !== OP_ADD) begin bad++; $display("FAIL rst_pre_issue got=busy%0b op%0h exp=busy1 op2", busy, alu_operation); end
        #1;
        reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || alu_operation !== 4'd0 || alu_operand1 !== 32'd0) begin bad++; $display("FAIL rst_outputs got=busy%0b op%0h a%0h exp=0 0 0", busy, alu_operation, alu_operand1); end
        total++; if (rsp0_valid !== 1'b0 || rsp0_result !== 32'd0) begin bad++; $display("FAIL rst_rsp got=v%0b r%0h exp=v0 r0", rsp0_valid, rsp0_result); end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (rsp0_valid || rsp1_valid) begin bad++; $display("FAIL rst_no_rsp got=%b exp=00", {rsp0_valid, rsp1_valid}); end
            @(negedge clk);
        end
        req0_valid = 1; req1_valid = 1; rsp1_ready = 1;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL rst_tie got=%b exp=10", {req0_ready, req1_ready}); end
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_req0_add();
        test_req1_overflow();
        test_round_robin();
        test_fixed_prio();
        test_backpressure();
        test_reset_in_issue();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
